// File: rtl/fxp_disp_scheduler.sv
// fxp_disp_scheduler
//   Shares one 5-digit 7-segment display between three fixed-point sources
//   (operand A, operand B, ALU result). A round-robin arbiter picks a source.
//   The block latches its sign-magnitude Q9.6 value and converts it with a
//   16-cycle shift-add-3 engine: 9 integer steps, then 7 steps on the scaled
//   fraction. It then scans the digit registers onto a shared segment bus.
//
//   Optional build macro: FXP_DISP_OVF_EN
//     defined   -> integer part >99 shows '-' on tens/units/tenths/hundredths
//     undefined -> hundreds digit dropped (value shown mod 100)
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   req_i    : per-requester level request, held until ack (0=A, 1=B, 2=result)
//   val_a_i  : operand A, [15]=sign, [14:6]=integer, [5:0]=fraction/64
//   val_b_i  : operand B, same format
//   val_r_i  : result, same format
//   ack_o    : one-hot one-cycle pulse, granted value is now on the display
//   busy_o   : high from the grant edge through the DONE cycle
//   src_o    : requester currently displayed (3 = none since reset)
//   seg_o    : shared segments, active-low, gfedcba
//   an_o     : active-low digit enables (0=sign,1=tens,2=units,3=tenths,4=hundredths)
module fxp_disp_scheduler #(
  parameter int SCAN_DIV = 50000,
  parameter int NREQ     = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic [15:0]     val_a_i,
  input  logic [15:0]     val_b_i,
  input  logic [15:0]     val_r_i,
  output logic [NREQ-1:0] ack_o,
  output logic            busy_o,
  output logic [1:0]      src_o,
  output logic [6:0]      seg_o,
  output logic [4:0]      an_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Active-low gfedcba code for one BCD digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // One double-dabble step: {hundreds,tens,units,bin[8:0]}.
  function automatic logic [20:0] dd_int(input logic [20:0] sr);
    logic [20:0] t;
    t = sr;
    for (int k = 0; k < 3; k++)
      if (t[9+4*k +: 4] >= 4'd5) t[9+4*k +: 4] = t[9+4*k +: 4] + 4'd3;
    dd_int = {t[19:0], 1'b0};
  endfunction

  // One double-dabble step: {tenths,hundredths,bin[6:0]}.
  function automatic logic [14:0] dd_frac(input logic [14:0] sr);
    logic [14:0] t;
    t = sr;
    for (int k = 0; k < 2; k++)
      if (t[7+4*k +: 4] >= 4'd5) t[7+4*k +: 4] = t[7+4*k +: 4] + 4'd3;
    dd_frac = {t[13:0], 1'b0};
  endfunction

  logic [1:0]       state_q, ptr_q, gnt_q, src_q;
  logic [3:0]       cnt_q;
  logic [NREQ-1:0]  ack_q;
  logic             busy_q, sign_q;
  logic [20:0]      int_sr_q;
  logic [14:0]      frac_sr_q, frac_sr_d;
  logic [4:0][6:0]  dig_q, dig_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [6:0]       seg_q;
  logic [4:0]       an_q;

  logic [1:0]  gnt_c;
  logic        any_req;
  logic [15:0] sel_val;
  logic [6:0]  frac_scaled;
  logic        conv_last;
  int          c;

  // Round-robin: search upward starting just after the last winner.
  always_comb begin
    gnt_c   = ptr_q;
    any_req = 1'b0;
    c       = 0;
    for (int i = 1; i <= NREQ; i++) begin
      c = (int'(ptr_q) + i) % NREQ;
      if (!any_req && req_i[c]) begin
        any_req = 1'b1;
        gnt_c   = 2'(c);
      end
    end
  end

  always_comb begin
    case (gnt_c)
      2'd0:    sel_val = val_a_i;
      2'd1:    sel_val = val_b_i;
      default: sel_val = val_r_i;
    endcase
    // Hundredths of the 6-bit fraction, truncated: 0..98 fits in 7 bits.
    frac_scaled = 7'((13'(sel_val[5:0]) * 13'd100) >> 6);
  end

  assign conv_last = (state_q == S_CONV) && (cnt_q == 4'd15);
  assign frac_sr_d = dd_frac(frac_sr_q);

  // Digit registers update only on the final conversion step.
  always_comb begin
    dig_d = dig_q;
    if (conv_last) begin
      dig_d[0] = sign_q ? SEG_DASH : SEG_BLANK;
      dig_d[1] = (int_sr_q[16:13] == 4'd0) ? SEG_BLANK : seg7(int_sr_q[16:13]);
      dig_d[2] = seg7(int_sr_q[12:9]);
      dig_d[3] = seg7(frac_sr_d[14:11]);
      dig_d[4] = seg7(frac_sr_d[10:7]);
`ifdef FXP_DISP_OVF_EN
      if (int_sr_q[20:17] != 4'd0) begin
        dig_d[1] = SEG_DASH;
        dig_d[2] = SEG_DASH;
        dig_d[3] = SEG_DASH;
        dig_d[4] = SEG_DASH;
      end
`endif
    end
  end

  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // Control path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ptr_q   <= 2'(NREQ - 1);
      gnt_q   <= 2'd0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      src_q   <= 2'd3;
      dig_q   <= {5{SEG_BLANK}};
    end else begin
      dig_q <= dig_d;
      case (state_q)
        S_IDLE: begin
          ack_q <= '0;
          if (any_req) begin
            gnt_q   <= gnt_c;
            ptr_q   <= gnt_c;
            busy_q  <= 1'b1;
            cnt_q   <= 4'd0;
            state_q <= S_CONV;
          end
        end
        S_CONV: begin
          cnt_q <= cnt_q + 4'd1;
          if (conv_last) begin
            ack_q   <= NREQ'(1) << gnt_q;
            src_q   <= gnt_q;
            state_q <= S_DONE;
          end
        end
        default: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Conversion datapath
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && any_req) begin
      sign_q    <= sel_val[15];
      int_sr_q  <= {12'd0, sel_val[14:6]};
      frac_sr_q <= {8'd0, frac_scaled};
    end else if (state_q == S_CONV) begin
      if (cnt_q < 4'd9) int_sr_q  <= dd_int(int_sr_q);
      else              frac_sr_q <= frac_sr_d;
    end
  end

  // Display scan, free-running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= 3'd0;
      seg_q <= SEG_BLANK;
      an_q  <= 5'b11110;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      seg_q <= dig_d[idx_d];
      an_q  <= ~(5'b00001 << idx_d);
    end
  end

  assign ack_o  = ack_q;
  assign busy_o = busy_q;
  assign src_o  = src_q;
  assign seg_o  = seg_q;
  assign an_o   = an_q;

endmodule

// File: tb/tb_fxp_disp_scheduler.sv
module tb_fxp_disp_scheduler;
  localparam int SD = 4;
`ifdef FXP_DISP_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif
  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] DS = 7'h3F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] req_i = 3'b000;
  logic [15:0] val_a_i = 16'h0, val_b_i = 16'h0, val_r_i = 16'h0;
  logic [2:0] ack_o;
  logic busy_o;
  logic [1:0] src_o;
  logic [6:0] seg_o;
  logic [4:0] an_o;

  fxp_disp_scheduler #(.SCAN_DIV(SD), .NREQ(3)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .val_a_i(val_a_i), .val_b_i(val_b_i),
    .val_r_i(val_r_i), .ack_o(ack_o), .busy_o(busy_o), .src_o(src_o),
    .seg_o(seg_o), .an_o(an_o));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [15:0] val;
    logic [1:0]  src;
    logic [6:0]  sg, tn, un, tt, hd;
    bit          ovf;
  } vec_t;
  vec_t vecs[7];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Collect the five scanned digit codes; index 0 = sign.
  task automatic read_digits(output logic [4:0][6:0] got, output logic [4:0] mask);
    got = '0;
    mask = '0;
    for (int t = 0; t < 60 && mask != 5'h1F; t++) begin
      @(negedge clk);
      for (int k = 0; k < 5; k++)
        if (an_o == ~(5'b00001 << k)) begin
          got[k] = seg_o;
          mask[k] = 1'b1;
        end
    end
  endtask

  task automatic run_vec(input int i);
    int t;
    logic [4:0][6:0] got;
    logic [4:0] mask;
    logic [6:0] e_tn, e_un, e_tt, e_hd;
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    val_a_i = (v.req == 3'b001) ? v.val : 16'h2A0F;
    val_b_i = (v.req == 3'b010) ? v.val : 16'h2A0F;
    val_r_i = (v.req == 3'b100) ? v.val : 16'h2A0F;
    req_i = v.req;
    t = 0;
    do begin @(negedge clk); t++; end while (!busy_o && t < 8);
    check($sformatf("v%0d_grant", i), busy_o, 1);
    // Drop the request and scramble inputs: conversion must carry on unaffected.
    req_i = 3'b000;
    val_a_i = 16'hFFFF; val_b_i = 16'hFFFF; val_r_i = 16'hFFFF;
    t = 0;
    while (ack_o == 3'b000 && t < 40) begin @(negedge clk); t++; end
    check($sformatf("v%0d_latency", i), t, 16);
    check($sformatf("v%0d_ack", i), ack_o, v.req);
    check($sformatf("v%0d_src", i), src_o, v.src);
    check($sformatf("v%0d_busy_at_ack", i), busy_o, 1);
    @(negedge clk);
    check($sformatf("v%0d_ack_off", i), ack_o, 0);
    check($sformatf("v%0d_busy_off", i), busy_o, 0);
    read_digits(got, mask);
    e_tn = (v.ovf && OVF_ON) ? DS : v.tn;
    e_un = (v.ovf && OVF_ON) ? DS : v.un;
    e_tt = (v.ovf && OVF_ON) ? DS : v.tt;
    e_hd = (v.ovf && OVF_ON) ? DS : v.hd;
    check($sformatf("v%0d_scan_all", i), mask, 5'h1F);
    check($sformatf("v%0d_sign", i), got[0], v.sg);
    check($sformatf("v%0d_tens", i), got[1], e_tn);
    check($sformatf("v%0d_units", i), got[2], e_un);
    check($sformatf("v%0d_tenths", i), got[3], e_tt);
    check($sformatf("v%0d_hundredths", i), got[4], e_hd);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] an_exp [6];
    logic [4:0] prev;
    logic [2:0] ack_seen [4];
    logic [1:0] src_seen [4];
    int         when [4];
    int         last, nchg, k, t, nack;
    logic [4:0][6:0] got;
    logic [4:0] mask;

    //          req     val       src  sign tens   units  tenths hund  ovf
    vecs[0] = '{3'b001, 16'h0A60, 2'd0, BL, 7'h19, 7'h79, 7'h12, 7'h40, 1'b0}; // 41.50
    vecs[1] = '{3'b100, 16'h8041, 2'd2, DS, BL,    7'h79, 7'h40, 7'h79, 1'b0}; // -1.01
    vecs[2] = '{3'b010, 16'h003F, 2'd1, BL, BL,    7'h40, 7'h10, 7'h00, 1'b0}; // 0.98
    vecs[3] = '{3'b001, 16'h3E80, 2'd0, BL, 7'h12, 7'h40, 7'h40, 7'h40, 1'b1}; // 250.00
    vecs[4] = '{3'b010, 16'h98FF, 2'd1, DS, 7'h10, 7'h10, 7'h10, 7'h00, 1'b0}; // -99.98
    vecs[5] = '{3'b100, 16'h1900, 2'd2, BL, BL,    7'h40, 7'h40, 7'h40, 1'b1}; // 100.00
    vecs[6] = '{3'b001, 16'h0290, 2'd0, BL, 7'h79, 7'h40, 7'h24, 7'h12, 1'b0}; // 10.25

    an_exp = '{5'b11101, 5'b11011, 5'b10111, 5'b01111, 5'b11110, 5'b11101};

    // Reset state and scan stepping
    do_reset();
    check("rst_seg", seg_o, 7'h7F);
    check("rst_an", an_o, 5'b11110);
    check("rst_ack", ack_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_src", src_o, 2'd3);
    prev = an_o;
    last = 0;
    nchg = 0;
    for (int c = 1; c <= 40 && nchg < 6; c++) begin
      @(negedge clk);
      if (an_o != prev) begin
        check($sformatf("scan_an%0d", nchg), an_o, an_exp[nchg]);
        check($sformatf("scan_gap%0d", nchg), c - last, SD);
        last = c;
        prev = an_o;
        nchg++;
      end
    end
    check("scan_changes", nchg, 6);

    // Directed conversion vectors
    for (int i = 0; i < 7; i++) run_vec(i);

    // All three requesting from reset: 0,1,2,0 at 18-cycle spacing
    do_reset();
    val_a_i = 16'h0A60; val_b_i = 16'h8041; val_r_i = 16'h003F;
    req_i = 3'b111;
    k = 0;
    for (int c = 1; c <= 120 && k < 4; c++) begin
      @(negedge clk);
      if (ack_o != 3'b000) begin
        ack_seen[k] = ack_o;
        src_seen[k] = src_o;
        when[k] = c;
        k++;
      end
    end
    req_i = 3'b000;
    check("rr_count", k, 4);
    check("rr_first_time", when[0], 17);
    check("rr_ack0", ack_seen[0], 3'b001);
    check("rr_ack1", ack_seen[1], 3'b010);
    check("rr_ack2", ack_seen[2], 3'b100);
    check("rr_ack3", ack_seen[3], 3'b001);
    check("rr_src0", src_seen[0], 2'd0);
    check("rr_src1", src_seen[1], 2'd1);
    check("rr_src2", src_seen[2], 2'd2);
    check("rr_src3", src_seen[3], 2'd0);
    for (int j = 1; j < 4; j++) check($sformatf("rr_gap%0d", j), when[j] - when[j-1], 18);
    t = 0;
    while (busy_o && t < 10) begin @(negedge clk); t++; end

    // Reset during conversion cycle 5 (pointer at 0 beforehand)
    @(negedge clk);
    val_a_i = 16'h0A60;
    req_i = 3'b001;
    t = 0;
    do begin @(negedge clk); t++; end while (!busy_o && t < 8);
    check("mid_grant", busy_o, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_seg", seg_o, 7'h7F);
    check("mid_an", an_o, 5'b11110);
    check("mid_ack", ack_o, 0);
    check("mid_busy", busy_o, 0);
    check("mid_src", src_o, 2'd3);
    @(negedge clk);
    rst = 1'b0;
    req_i = 3'b000;
    nack = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ack_o != 3'b000) nack++;
    end
    check("mid_no_ack", nack, 0);
    read_digits(got, mask);
    check("mid_blank_digits", got, {5{7'h7F}});
    // Pointer back at 2, so requester 0 beats requester 1
    req_i = 3'b011;
    t = 0;
    while (ack_o == 3'b000 && t < 40) begin @(negedge clk); t++; end
    check("mid_ptr_ack", ack_o, 3'b001);
    req_i = 3'b000;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
